// File: rtl/redirect_controller_pkg.sv
// Shared pipeline types for the control-flow redirect path.
package redirect_controller_pkg;

    localparam int PIPE_XLEN = 64;

    typedef enum logic [1:0] {
        PC_From_add4    = 2'd0,
        PC_From_add_imm = 2'd1,
        PC_From_jalr    = 2'd2
    } PcSelect;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } redirect_state_t;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] target;
        logic                 misaligned;
    } redirect_req_t;

    // Only these selects describe a real change of control flow.
    function automatic logic sel_is_redirect(input PcSelect sel);
        return (sel == PC_From_add_imm) || (sel == PC_From_jalr);
    endfunction

endpackage

// File: rtl/redirect_controller_if.sv
// Bundle between memory-stage branch logic, fetch/ibus and PC register.
interface redirect_controller_if
    import redirect_controller_pkg::*;
#(
    parameter int XLEN  = PIPE_XLEN,
    parameter int CNT_W = 32
) ();

    logic             mem_valid;
    logic             mem_stall;
    logic             br_flush;
    PcSelect          br_pc_select;
    logic [XLEN-1:0]  mem_pc;
    logic [XLEN-1:0]  mem_imm;
    logic [XLEN-1:0]  mem_rs1;
    logic             ireq_valid;
    logic             iresp_data_ok;
    logic             pc_stall;

    logic             flush_if;
    logic             flush_id;
    logic             flush_ex;
    logic             fetch_hold;
    logic             drop_iresp;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             target_misaligned;
    logic [CNT_W-1:0] redirect_count;

    modport master (
        output mem_valid, mem_stall, br_flush, br_pc_select, mem_pc, mem_imm, mem_rs1,
        output ireq_valid, iresp_data_ok, pc_stall,
        input  flush_if, flush_id, flush_ex, fetch_hold, drop_iresp,
        input  redirect_valid, redirect_pc, target_misaligned, redirect_count
    );

    modport slave (
        input  mem_valid, mem_stall, br_flush, br_pc_select, mem_pc, mem_imm, mem_rs1,
        input  ireq_valid, iresp_data_ok, pc_stall,
        output flush_if, flush_id, flush_ex, fetch_hold, drop_iresp,
        output redirect_valid, redirect_pc, target_misaligned, redirect_count
    );

endinterface

// File: rtl/redirect_target_calc.sv
// Combinational branch/jump target and alignment check.
module redirect_target_calc
    import redirect_controller_pkg::*;
(
    input  PcSelect               i_sel,
    input  logic [PIPE_XLEN-1:0]  i_pc,
    input  logic [PIPE_XLEN-1:0]  i_imm,
    input  logic [PIPE_XLEN-1:0]  i_rs1,
    output redirect_req_t         o_req
);

    logic [PIPE_XLEN-1:0] w_target;

    always_comb begin
        w_target = '0;
        case (i_sel)
            PC_From_add_imm: w_target = i_pc + i_imm;
            // jalr clears bit 0 of the sum; bit 1 may still be set
            PC_From_jalr:    w_target = (i_rs1 + i_imm) & {{(PIPE_XLEN-1){1'b1}}, 1'b0};
            default:         w_target = i_pc + PIPE_XLEN'(4);
        endcase
    end

    assign o_req.target     = w_target;
    assign o_req.misaligned = (w_target[1:0] != 2'b00);

endmodule

// File: rtl/redirect_controller.sv
// Redirect sequencer: flush pulse, ibus drain, then hold redirect PC until accepted.
//   state    | meaning
//   IDLE     | no redirect pending; trigger accepted here only
//   DRAIN    | waiting for in-flight ibus response to discard
//   REDIRECT | redirect_pc presented until PC register accepts
module redirect_controller
    import redirect_controller_pkg::*;
#(
    parameter int XLEN  = PIPE_XLEN,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    redirect_controller_if.slave bus
);

    redirect_state_t  r_state;
    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_target;
    logic             r_misaligned;
    PcSelect          r_sel;
    logic [CNT_W-1:0] r_count;

    redirect_req_t    w_req;
    logic             w_idle;
    logic             w_branch_raw;
    logic             w_trigger;

    redirect_target_calc u_target_calc (
        .i_sel (bus.br_pc_select),
        .i_pc  (bus.mem_pc),
        .i_imm (bus.mem_imm),
        .i_rs1 (bus.mem_rs1),
        .o_req (w_req)
    );

    assign w_idle       = (r_state == IDLE);
    assign w_branch_raw = bus.mem_valid & bus.br_flush & ~bus.mem_stall & w_idle & ~reset;
    assign w_trigger    = w_branch_raw & sel_is_redirect(bus.br_pc_select);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_redirect_valid <= 1'b0;
            r_target         <= '0;
            r_misaligned     <= 1'b0;
            r_sel            <= PC_From_add4;
            r_count          <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_target     <= XLEN'(w_req.target);
                        r_misaligned <= w_req.misaligned;
                        r_sel        <= bus.br_pc_select;
                        if (bus.ireq_valid && !bus.iresp_data_ok) begin
                            r_state <= DRAIN;
                        end else begin
                            r_state          <= REDIRECT;
                            r_redirect_valid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.iresp_data_ok) begin
                        r_state          <= REDIRECT;
                        r_redirect_valid <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (!bus.pc_stall) begin
                        r_state          <= IDLE;
                        r_redirect_valid <= 1'b0;
                        r_count          <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state          <= IDLE;
                    r_redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    // A response arriving while the redirect is being set up is wrong-path.
    assign bus.drop_iresp        = bus.iresp_data_ok & (w_trigger | (r_state == DRAIN));
    assign bus.flush_if          = w_trigger;
    assign bus.flush_id          = w_trigger;
    assign bus.flush_ex          = w_trigger;
    assign bus.fetch_hold        = w_trigger | ~w_idle;
    assign bus.redirect_valid    = r_redirect_valid;
    assign bus.redirect_pc       = r_target;
    assign bus.target_misaligned = r_misaligned;
    assign bus.redirect_count    = r_count;

    a_no_add4_flush: assert property (@(posedge clk) disable iff (reset)
        !(w_branch_raw && !sel_is_redirect(bus.br_pc_select)));

    a_upstream_quiet: assert property (@(posedge clk) disable iff (reset)
        !(!w_idle && bus.mem_valid && bus.br_flush));

    a_redirect_sel_legal: assert property (@(posedge clk) disable iff (reset)
        (r_state == REDIRECT) |-> sel_is_redirect(r_sel));

endmodule
